// File: rtl/exc_ctrl.sv
// Exception control unit for the LEGv8 pipeline: synchronises the external IRQ,
// sequences exception entry/return and redirects fetch with a pipeline flush.
module exc_ctrl #(
    parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ExtIRQ_raw,
    input  logic             Exc,
    input  logic [3:0]       EStatus,
    input  logic             ERet,
    input  logic [63:0]      PC_dec,
    output logic             ExtIRQ,
    output logic             ExtIAck,
    output logic             Flush,
    output logic             PCSel_exc,
    output logic [63:0]      PC_exc,
    output logic [63:0]      ELR,
    output logic [3:0]       ESR,
    output logic             InHandler,
    output logic [CNT_W-1:0] ExcCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             irq_prev_q, irq_prev_d;
    logic             pend_q, pend_d;
    logic [63:0]      elr_q, elr_d;
    logic [3:0]       esr_q, esr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_rise;
    logic             ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            irq_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            elr_q      <= 64'd0;
            esr_q      <= 4'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            irq_prev_q <= irq_prev_d;
            pend_q     <= pend_d;
            elr_q      <= elr_d;
            esr_q      <= esr_d;
            cnt_q      <= cnt_d;
        end
    end

    // IRQ synchroniser and pending flag; a fresh edge beats the acknowledge.
    always_comb begin
        sync1_d    = ExtIRQ_raw;
        sync2_d    = sync1_q;
        irq_prev_d = sync2_q;
        irq_rise   = sync2_q & ~irq_prev_q;
        ack        = (state_q == TAKE) && (esr_q == 4'b0001);
        pend_d     = pend_q;
        if (irq_rise) begin
            pend_d = 1'b1;
        end else if (ack) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        elr_d   = elr_q;
        esr_d   = esr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Exc) begin
                    state_d = TAKE;
                    elr_d   = PC_dec;
                    esr_d   = EStatus;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            TAKE:    state_d = HANDLER;
            HANDLER: begin
                if (ERet) begin
                    state_d = RETURN;
                end
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ExtIRQ    = pend_q & (state_q == IDLE);
        ExtIAck   = ack;
        Flush     = 1'b0;
        PCSel_exc = 1'b0;
        PC_exc    = 64'd0;
        InHandler = (state_q == TAKE) || (state_q == HANDLER);
        ELR       = elr_q;
        ESR       = esr_q;
        ExcCount  = cnt_q;
        if (state_q == TAKE) begin
            Flush     = 1'b1;
            PCSel_exc = 1'b1;
            PC_exc    = EXC_VECTOR;
        end else if (state_q == RETURN) begin
            Flush     = 1'b1;
            PCSel_exc = 1'b1;
            PC_exc    = elr_q;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed stimulus queues expected outputs per
// cycle; a negedge monitor pops and compares them independently.
module tb_exc_ctrl;

    typedef struct packed {
        logic        irq;
        logic        ack;
        logic        flush;
        logic        pcsel;
        logic [63:0] pc;
        logic [63:0] elr;
        logic [3:0]  esr;
        logic        inh;
        logic [7:0]  cnt;
    } out_t;

    typedef struct {
        int    cyc;
        string name;
        out_t  exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ExtIRQ_raw;
    logic        Exc;
    logic [3:0]  EStatus;
    logic        ERet;
    logic [63:0] PC_dec;
    logic        ExtIRQ;
    logic        ExtIAck;
    logic        Flush;
    logic        PCSel_exc;
    logic [63:0] PC_exc;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        InHandler;
    logic [7:0]  ExcCount;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    exc_ctrl #(.EXC_VECTOR(64'h0000_0000_0000_00D8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ExtIRQ_raw(ExtIRQ_raw), .Exc(Exc),
        .EStatus(EStatus), .ERet(ERet), .PC_dec(PC_dec), .ExtIRQ(ExtIRQ),
        .ExtIAck(ExtIAck), .Flush(Flush), .PCSel_exc(PCSel_exc), .PC_exc(PC_exc),
        .ELR(ELR), .ESR(ESR), .InHandler(InHandler), .ExcCount(ExcCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic out_t mk(input logic irq, input logic ack, input logic flush,
                                input logic pcsel, input logic [63:0] pc,
                                input logic [63:0] elr, input logic [3:0] esr,
                                input logic inh, input logic [7:0] cnt);
        out_t o;
        o.irq = irq; o.ack = ack; o.flush = flush; o.pcsel = pcsel; o.pc = pc;
        o.elr = elr; o.esr = esr; o.inh = inh; o.cnt = cnt;
        return o;
    endfunction

    // Queue an expectation for the cycle 'off' edges from now.
    task automatic push_exp(input int off, input string name, input out_t e);
        exp_t r;
        r.cyc  = cyc + off;
        r.name = name;
        r.exp  = e;
        sb_q.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input exp_t r);
        out_t act;
        act = '{ExtIRQ, ExtIAck, Flush, PCSel_exc, PC_exc, ELR, ESR, InHandler, ExcCount};
        checks++;
        if (r.cyc != cyc || act !== r.exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d/%0d got irq=%b ack=%b fl=%b sel=%b pc=%h elr=%h esr=%h inh=%b cnt=%0d want irq=%b ack=%b fl=%b sel=%b pc=%h elr=%h esr=%h inh=%b cnt=%0d",
                     r.name, cyc, r.cyc, act.irq, act.ack, act.flush, act.pcsel, act.pc,
                     act.elr, act.esr, act.inh, act.cnt, r.exp.irq, r.exp.ack,
                     r.exp.flush, r.exp.pcsel, r.exp.pc, r.exp.elr, r.exp.esr,
                     r.exp.inh, r.exp.cnt);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            check_output(sb_q.pop_front());
        end
    end

    // One exception entry plus return, used for the saturation run.
    task automatic exc_round(input logic [63:0] pc);
        Exc = 1'b1; EStatus = 4'b0010; PC_dec = pc;
        tick(1);
        Exc = 1'b0;
        tick(1);
        ERet = 1'b1;
        tick(1);
        ERet = 1'b0;
        tick(1);
    endtask

    task automatic apply_stimulus();
        // Reset held with Exc and the IRQ line active.
        reset = 1'b0; ExtIRQ_raw = 1'b1; Exc = 1'b1; EStatus = 4'b0010;
        ERet = 1'b0; PC_dec = 64'h0;
        tick(2);
        push_exp(0, "reset", mk(0,0,0,0,64'h0,64'h0,4'h0,0,8'd0));
        reset = 1'b1; ExtIRQ_raw = 1'b0; Exc = 1'b0;
        tick(1);
        push_exp(0, "idle_after_reset", mk(0,0,0,0,64'h0,64'h0,4'h0,0,8'd0));

        // Invalid opcode exception.
        Exc = 1'b1; EStatus = 4'b0010; PC_dec = 64'h40;
        push_exp(1, "invop_take", mk(0,0,1,1,64'hD8,64'h40,4'h2,1,8'd1));
        tick(1);
        Exc = 1'b0; PC_dec = 64'h0;
        push_exp(1, "invop_handler", mk(0,0,0,0,64'h0,64'h40,4'h2,1,8'd1));
        tick(1);

        // Nested exception ignored in HANDLER.
        Exc = 1'b1; EStatus = 4'b0001; PC_dec = 64'h80;
        push_exp(1, "nest_ignored", mk(0,0,0,0,64'h0,64'h40,4'h2,1,8'd1));
        tick(1);
        Exc = 1'b0; ERet = 1'b1;
        push_exp(1, "eret_return", mk(0,0,1,1,64'h40,64'h40,4'h2,0,8'd1));
        tick(1);
        ERet = 1'b0;
        push_exp(1, "eret_idle", mk(0,0,0,0,64'h0,64'h40,4'h2,0,8'd1));
        tick(1);

        // ERET outside the handler does nothing.
        ERet = 1'b1;
        push_exp(1, "eret_in_idle", mk(0,0,0,0,64'h0,64'h40,4'h2,0,8'd1));
        tick(1);
        ERet = 1'b0;

        // One-cycle IRQ pulse, then take it.
        ExtIRQ_raw = 1'b1;
        push_exp(1, "irq_lat1", mk(0,0,0,0,64'h0,64'h40,4'h2,0,8'd1));
        push_exp(2, "irq_lat2", mk(0,0,0,0,64'h0,64'h40,4'h2,0,8'd1));
        push_exp(3, "irq_pending", mk(1,0,0,0,64'h0,64'h40,4'h2,0,8'd1));
        tick(1);
        ExtIRQ_raw = 1'b0;
        tick(2);
        Exc = 1'b1; EStatus = 4'b0001; PC_dec = 64'h100;
        push_exp(1, "irq_take_ack", mk(0,1,1,1,64'hD8,64'h100,4'h1,1,8'd2));
        tick(1);
        Exc = 1'b0;
        push_exp(1, "irq_handler", mk(0,0,0,0,64'h0,64'h100,4'h1,1,8'd2));
        tick(1);
        ERet = 1'b1;
        push_exp(1, "irq_return", mk(0,0,1,1,64'h100,64'h100,4'h1,0,8'd2));
        tick(1);
        ERet = 1'b0;
        push_exp(1, "irq_cleared", mk(0,0,0,0,64'h0,64'h100,4'h1,0,8'd2));
        tick(1);

        // Exc and ERet together in IDLE: Exc wins.
        Exc = 1'b1; ERet = 1'b1; EStatus = 4'b0010; PC_dec = 64'h200;
        push_exp(1, "simul_take", mk(0,0,1,1,64'hD8,64'h200,4'h2,1,8'd3));
        tick(1);
        Exc = 1'b0; ERet = 1'b0;
        push_exp(1, "simul_handler", mk(0,0,0,0,64'h0,64'h200,4'h2,1,8'd3));
        tick(1);
        ERet = 1'b1;
        push_exp(1, "simul_return", mk(0,0,1,1,64'h200,64'h200,4'h2,0,8'd3));
        tick(1);
        ERet = 1'b0;
        tick(1);

        // IRQ arriving during a handler is held, masked, then presented in IDLE.
        ExtIRQ_raw = 1'b1; Exc = 1'b1; EStatus = 4'b0010; PC_dec = 64'h300;
        push_exp(1, "mask_take", mk(0,0,1,1,64'hD8,64'h300,4'h2,1,8'd4));
        tick(1);
        ExtIRQ_raw = 1'b0; Exc = 1'b0;
        push_exp(1, "mask_h1", mk(0,0,0,0,64'h0,64'h300,4'h2,1,8'd4));
        tick(1);
        push_exp(1, "mask_h2", mk(0,0,0,0,64'h0,64'h300,4'h2,1,8'd4));
        tick(1);
        ERet = 1'b1;
        push_exp(1, "mask_return", mk(0,0,1,1,64'h300,64'h300,4'h2,0,8'd4));
        tick(1);
        ERet = 1'b0;
        push_exp(1, "mask_released", mk(1,0,0,0,64'h0,64'h300,4'h2,0,8'd4));
        tick(1);
        Exc = 1'b1; EStatus = 4'b0001; PC_dec = 64'h308;
        push_exp(1, "held_take_ack", mk(0,1,1,1,64'hD8,64'h308,4'h1,1,8'd5));
        tick(1);
        Exc = 1'b0;
        push_exp(1, "held_handler", mk(0,0,0,0,64'h0,64'h308,4'h1,1,8'd5));
        tick(1);
        ERet = 1'b1;
        tick(1);
        ERet = 1'b0;
        push_exp(1, "held_idle", mk(0,0,0,0,64'h0,64'h308,4'h1,0,8'd5));
        tick(1);

        // Saturation: 5 + 260 rounds clamps at 255.
        for (int i = 0; i < 260; i++) begin
            exc_round(64'h500);
        end
        push_exp(0, "saturated", mk(0,0,0,0,64'h0,64'h500,4'h2,0,8'd255));

        // Reset in the middle of a handler abandons it without a redirect.
        Exc = 1'b1; EStatus = 4'b0010; PC_dec = 64'h600;
        push_exp(1, "sat_take", mk(0,0,1,1,64'hD8,64'h600,4'h2,1,8'd255));
        tick(1);
        Exc = 1'b0; ERet = 1'b1;
        push_exp(1, "pre_reset_handler", mk(0,0,0,0,64'h0,64'h600,4'h2,1,8'd255));
        tick(1);
        reset = 1'b0;
        push_exp(1, "mid_reset", mk(0,0,0,0,64'h0,64'h0,4'h0,0,8'd0));
        tick(1);
        reset = 1'b1;
        push_exp(1, "no_redirect", mk(0,0,0,0,64'h0,64'h0,4'h0,0,8'd0));
        tick(1);
        ERet = 1'b0;
    endtask

    initial begin
        apply_stimulus();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            tick(1);
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
